// File: rtl/eqv_mon_pkg.sv
// ============================================================
// eqv_mon_pkg : shared types and helpers for eqv_pair_monitor
// Revision: 1.0
// ============================================================
`default_nettype none

package eqv_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam int DEF_CNT_W   = 16;
  localparam int DEF_RUN_LEN = 256;

  // Right-aligned mask of 'width' ones; callers truncate to their own width.
  function automatic logic [63:0] all_ones(input int width);
    return {64{1'b1}} >> (64 - width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================
// sat_counter : clearable up-counter that holds at all-ones
// Revision: 1.0
// ============================================================
`default_nettype none

module sat_counter
  import eqv_mon_pkg::*;
#(
  parameter int WIDTH = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] c_max = WIDTH'(all_ones(WIDTH));
  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != c_max)) begin
      cnt <= cnt + c_one;
    end
  end

endmodule

`default_nettype wire

// File: rtl/eqv_pair_monitor.sv
// ============================================================
// eqv_pair_monitor : windowed o1/o2 mismatch checker with result record
// Revision: 1.0
// ============================================================
`default_nettype none

module eqv_pair_monitor
  import eqv_mon_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int RUN_LEN = DEF_RUN_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             o1,
  input  logic             o2,
  output logic             busy,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic             rpt_pass,
  output logic [CNT_W-1:0] rpt_fail_cnt,
  output logic [CNT_W-1:0] rpt_first_fail
);

  localparam logic [CNT_W-1:0] c_ones = CNT_W'(all_ones(CNT_W));
  localparam logic [CNT_W-1:0] c_last = CNT_W'(RUN_LEN - 1);
  localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_first;
  logic             r_seen;
  logic             r_pass;
  logic             w_mis;
  logic             w_run_entry;
  logic             w_inc;
  logic             w_last;
  logic [CNT_W-1:0] w_cnt;

  assign w_mis       = o1 ^ o2;
  assign w_run_entry = (r_state == IDLE) && start;
  assign w_inc       = (r_state == RUN) && w_mis;
  assign w_last      = (r_idx == c_last);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)     w_next = RUN;
      RUN:     if (w_last)    w_next = REPORT;
      REPORT:  if (rpt_ready) w_next = IDLE;
      default:                w_next = IDLE;
    endcase
  end

  // Pass is resolved on the last sample so the report fields are all registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idx   <= '0;
      r_first <= c_ones;
      r_seen  <= 1'b0;
      r_pass  <= 1'b0;
    end else if (w_run_entry) begin
      r_idx   <= '0;
      r_first <= c_ones;
      r_seen  <= 1'b0;
      r_pass  <= 1'b0;
    end else if (r_state == RUN) begin
      if (w_mis && !r_seen) begin
        r_first <= r_idx;
        r_seen  <= 1'b1;
      end
      if (w_last) begin
        r_pass <= !(r_seen || w_mis);
      end else begin
        r_idx <= r_idx + c_one;
      end
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_fail_cnt (
    .clk (clk),
    .rst (rst),
    .clr (w_run_entry),
    .inc (w_inc),
    .cnt (w_cnt)
  );

  assign busy           = (r_state != IDLE);
  assign rpt_valid      = (r_state == REPORT);
  assign rpt_pass       = r_pass;
  assign rpt_fail_cnt   = w_cnt;
  assign rpt_first_fail = r_first;

endmodule

`default_nettype wire
